// File: rtl/jtframe_rom_narb_pkg.sv
// Shared constants and FSM encoding for the N-slot SDRAM ROM arbiter.
package jtframe_rom_narb_pkg;

    localparam int unsigned SDRAM_AW = 22;
    localparam int unsigned DW       = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } state_t;

endpackage

// File: rtl/jtframe_rom_ncache.sv
// One-word cache for a single ROM slot: valid/tag/data with hit compare and fill/flush.
module jtframe_rom_ncache
    import jtframe_rom_narb_pkg::*;
#(
    parameter int unsigned AW = 22
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          flush,
    input  logic          fill,
    input  logic [AW-1:0] fill_tag,
    input  logic [DW-1:0] fill_data,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    output logic          hit_c,
    output logic          ok_c,
    output logic [DW-1:0] dout
);

    logic          valid;
    logic [AW-1:0] tag;

    // Flush wins over fill so ROM reloads and loop resets never keep stale data.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid <= 1'b0;
            tag   <= '0;
            dout  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (fill) begin
            valid <= 1'b1;
            tag   <= fill_tag;
            dout  <= fill_data;
        end
    end

    assign hit_c = valid && (tag == addr);
    assign ok_c  = cs && hit_c;

endmodule

// File: rtl/jtframe_rom_narb.sv
// Parametrised N-slot ROM arbiter: per-slot word caches, misses serialised onto one SDRAM read port.
module jtframe_rom_narb
    import jtframe_rom_narb_pkg::*;
#(
    parameter int unsigned                    SLOTS    = 4,
    parameter int unsigned                    AW       = 22,
    parameter logic [SLOTS*SDRAM_AW-1:0]      OFFSETS  = '0,
    parameter bit                             RR       = 1'b1,
    parameter int unsigned                    VBL_SLOT = SLOTS
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  vblank,
    input  logic                  downloading,
    input  logic                  loop_rst,
    input  logic [SLOTS-1:0]      slot_cs,
    input  logic [SLOTS*AW-1:0]   slot_addr,
    output logic [SLOTS-1:0]      slot_ok,
    output logic [SLOTS*DW-1:0]   slot_dout,
    output logic                  sdram_req,
    output logic [SDRAM_AW-1:0]   sdram_addr,
    input  logic                  sdram_ack,
    input  logic                  data_rdy,
    input  logic [DW-1:0]         data_read,
    output logic                  refresh_en
);

    localparam int unsigned GW      = $clog2(SLOTS);
    localparam bit          VBL_EN  = (VBL_SLOT < SLOTS);
    localparam int unsigned VBL_IDX = VBL_EN ? VBL_SLOT : 0;

    state_t                state, state_nx;
    logic [GW-1:0]         gnt, gnt_nx, rr_ptr, ptr_nx, win, sel;
    logic [AW-1:0]         lat_addr, lat_nx, win_addr;
    logic [SDRAM_AW-1:0]   win_off, saddr_nx;
    logic                  req_nx, win_vld, fill, flush, dl_q;
    logic [SLOTS-1:0]      hit, pending;
    logic [AW-1:0]         addr_arr [SLOTS];
    logic [SDRAM_AW-1:0]   off_arr  [SLOTS];
    int unsigned           idx;

    // A falling edge of downloading means the ROM image changed underneath the caches.
    assign flush = loop_rst || (dl_q && !downloading);

    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        assign addr_arr[i] = slot_addr[i*AW +: AW];
        assign off_arr[i]  = OFFSETS[i*SDRAM_AW +: SDRAM_AW];
        assign pending[i]  = slot_cs[i] && !hit[i];

        jtframe_rom_ncache #(.AW(AW)) u_cache (
            .clk       (clk),
            .rstn      (rstn),
            .flush     (flush),
            .fill      (fill && (gnt == GW'(i))),
            .fill_tag  (lat_addr),
            .fill_data (data_read),
            .cs        (slot_cs[i]),
            .addr      (addr_arr[i]),
            .hit_c     (hit[i]),
            .ok_c      (slot_ok[i]),
            .dout      (slot_dout[i*DW +: DW])
        );
    end

    // Winner select: vblank boost, else round-robin from rr_ptr or lowest index.
    always_comb begin
        win_vld  = 1'b0;
        win      = '0;
        win_addr = '0;
        win_off  = '0;
        sel      = '0;
        idx      = 0;
        if (VBL_EN && vblank && pending[VBL_IDX]) begin
            win_vld  = 1'b1;
            win      = GW'(VBL_IDX);
            win_addr = addr_arr[VBL_IDX];
            win_off  = off_arr[VBL_IDX];
        end else begin
            for (int unsigned k = 0; k < SLOTS; k++) begin
                idx = RR ? ((32'(rr_ptr) + k) % SLOTS) : k;
                sel = GW'(idx);
                if (!win_vld && pending[sel]) begin
                    win_vld  = 1'b1;
                    win      = sel;
                    win_addr = addr_arr[sel];
                    win_off  = off_arr[sel];
                end
            end
        end
    end

    // Next-state and request generation.
    always_comb begin
        state_nx = state;
        gnt_nx   = gnt;
        lat_nx   = lat_addr;
        ptr_nx   = rr_ptr;
        req_nx   = sdram_req;
        saddr_nx = sdram_addr;
        fill     = 1'b0;
        if (loop_rst) begin
            state_nx = ST_IDLE;
            req_nx   = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_vld && !downloading) begin
                        gnt_nx   = win;
                        lat_nx   = win_addr;
                        saddr_nx = win_off + SDRAM_AW'(win_addr);
                        req_nx   = 1'b1;
                        ptr_nx   = (win == GW'(SLOTS-1)) ? '0 : win + GW'(1);
                        state_nx = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (sdram_ack) begin
                        req_nx   = 1'b0;
                        state_nx = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (data_rdy) begin
                        fill     = 1'b1;
                        state_nx = ST_IDLE;
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            gnt        <= '0;
            lat_addr   <= '0;
            rr_ptr     <= '0;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
            dl_q       <= 1'b0;
        end else begin
            state      <= state_nx;
            gnt        <= gnt_nx;
            lat_addr   <= lat_nx;
            rr_ptr     <= ptr_nx;
            sdram_req  <= req_nx;
            sdram_addr <= saddr_nx;
            dl_q       <= downloading;
        end
    end

    assign refresh_en = (state == ST_IDLE) && !(|pending);

endmodule

// File: tb/tb_jtframe_rom_narb.sv
// Bench for jtframe_rom_narb: a round-robin and a fixed-priority instance share slot stimulus.
module tb_jtframe_rom_narb;

    logic         clk;
    logic         rstn, vblank, downloading, loop_rst;
    logic [3:0]   slot_cs;
    logic [87:0]  slot_addr;

    logic [3:0]   ok0, ok1;
    logic [127:0] dout0, dout1;
    logic         req0, req1, ack0, ack1, rdy0, rdy1, ref0, ref1;
    logic [21:0]  saddr0, saddr1;
    logic [31:0]  rd0, rd1;

    logic         auto0, chk1;
    logic         a_ack0, a_rdy0, m_ack0, m_rdy0;
    logic [31:0]  a_rd0, m_rd0;

    logic [21:0]  q0[$];
    logic [21:0]  q1[$];
    int           checks = 0;
    int           errors = 0;

    localparam logic [87:0] OFFS = {22'h0, 22'h0, 22'h8000, 22'h0};

    assign ack0 = auto0 ? a_ack0 : m_ack0;
    assign rdy0 = auto0 ? a_rdy0 : m_rdy0;
    assign rd0  = auto0 ? a_rd0  : m_rd0;

    jtframe_rom_narb #(.SLOTS(4), .AW(22), .OFFSETS(OFFS), .RR(1'b1), .VBL_SLOT(3)) dut_rr (
        .clk(clk), .rstn(rstn), .vblank(vblank), .downloading(downloading), .loop_rst(loop_rst),
        .slot_cs(slot_cs), .slot_addr(slot_addr), .slot_ok(ok0), .slot_dout(dout0),
        .sdram_req(req0), .sdram_addr(saddr0), .sdram_ack(ack0), .data_rdy(rdy0),
        .data_read(rd0), .refresh_en(ref0)
    );

    jtframe_rom_narb #(.SLOTS(4), .AW(22), .OFFSETS(OFFS), .RR(1'b0), .VBL_SLOT(3)) dut_fp (
        .clk(clk), .rstn(rstn), .vblank(vblank), .downloading(downloading), .loop_rst(loop_rst),
        .slot_cs(slot_cs), .slot_addr(slot_addr), .slot_ok(ok1), .slot_dout(dout1),
        .sdram_req(req1), .sdram_addr(saddr1), .sdram_ack(ack1), .data_rdy(rdy1),
        .data_read(rd1), .refresh_en(ref1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem(input logic [21:0] a);
        return (a == 22'h8010) ? 32'hDEADBEEF : {10'h2A5, a};
    endfunction

    task automatic set_slot(input int i, input logic [21:0] a, input logic cs);
        slot_addr[i*22 +: 22] = a;
        slot_cs[i]            = cs;
    endtask

    task automatic wait_req0(input string tag);
        int n = 0;
        while (!req0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_req"}, 32'(req0), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!(q0.size() == 0 && q1.size() == 0 && ref0 && ref1) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_q0"}, 32'(q0.size()), 32'd0);
        check({tag, "_q1"}, 32'(q1.size()), 32'd0);
        check({tag, "_idle"}, {31'b0, ref0 && ref1}, 32'd1);
    endtask

    // Scoreboarded SDRAM model for the round-robin instance.
    initial begin
        logic [21:0] a, e;
        a_ack0 = 1'b0; a_rdy0 = 1'b0; a_rd0 = '0;
        forever begin
            @(negedge clk);
            if (auto0 && rstn && req0) begin
                a = saddr0;
                e = (q0.size() != 0) ? q0.pop_front() : 22'h3FFFFF;
                check("sb_rr_addr", 32'(a), 32'(e));
                a_ack0 = 1'b1;
                @(negedge clk);
                a_ack0 = 1'b0; a_rdy0 = 1'b1; a_rd0 = mem(a);
                @(negedge clk);
                a_rdy0 = 1'b0;
            end
        end
    end

    // SDRAM model for the fixed-priority instance; scoreboard only while chk1 is set.
    initial begin
        logic [21:0] a, e;
        ack1 = 1'b0; rdy1 = 1'b0; rd1 = '0;
        forever begin
            @(negedge clk);
            if (rstn && req1) begin
                a = saddr1;
                if (chk1) begin
                    e = (q1.size() != 0) ? q1.pop_front() : 22'h3FFFFF;
                    check("sb_fp_addr", 32'(a), 32'(e));
                end
                ack1 = 1'b1;
                @(negedge clk);
                ack1 = 1'b0; rdy1 = 1'b1; rd1 = mem(a);
                @(negedge clk);
                rdy1 = 1'b0;
            end
        end
    end

    initial begin
        int n;
        rstn = 1'b0; vblank = 1'b0; downloading = 1'b0; loop_rst = 1'b0;
        slot_cs = '0; slot_addr = '0;
        auto0 = 1'b1; chk1 = 1'b1;
        m_ack0 = 1'b0; m_rdy0 = 1'b0; m_rd0 = '0;
        repeat (3) @(negedge clk);

        check("rst_req", 32'(req0), 32'd0);
        check("rst_addr", 32'(saddr0), 32'd0);
        check("rst_ok", 32'(ok0), 32'd0);
        for (int w = 0; w < 4; w++) check("rst_dout", dout0[w*32 +: 32], 32'd0);
        check("rst_refresh", 32'(ref0), 32'd1);
        rstn = 1'b1;
        @(negedge clk);

        // Grant order with simultaneous misses, then slot0 re-requests during slot2's fetch
        q0.push_back(22'h100); q0.push_back(22'h200); q0.push_back(22'h300); q0.push_back(22'h101);
        q1.push_back(22'h100); q1.push_back(22'h200); q1.push_back(22'h101); q1.push_back(22'h300);
        set_slot(0, 22'h100, 1'b1); set_slot(2, 22'h200, 1'b1); set_slot(3, 22'h300, 1'b1);
        n = 0;
        while (!(req0 && saddr0 == 22'h200) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t2_slot2_req", {31'b0, req0 && saddr0 == 22'h200}, 32'd1);
        set_slot(0, 22'h101, 1'b1);
        wait_done("t2");
        check("t2_ok_rr", 32'(ok0), 32'hD);
        check("t2_ok_fp", 32'(ok1), 32'hD);
        check("t2_dout3", dout0[127:96], mem(22'h300));
        check("t2_dout0", dout1[31:0], mem(22'h101));
        slot_cs = '0;
        @(negedge clk);
        auto0 = 1'b0;

        // Single miss through an offset slot, hand-driven SDRAM handshake
        q1.push_back(22'h8010);
        set_slot(1, 22'h10, 1'b1);
        @(negedge clk);
        check("t1_req", 32'(req0), 32'd1);
        check("t1_addr", 32'(saddr0), 32'h8010);
        check("t1_ok_early", 32'(ok0[1]), 32'd0);
        m_ack0 = 1'b1;
        @(negedge clk);
        m_ack0 = 1'b0;
        check("t1_req_drop", 32'(req0), 32'd0);
        m_rdy0 = 1'b1; m_rd0 = 32'hDEADBEEF;
        @(negedge clk);
        m_rdy0 = 1'b0;
        check("t1_ok", 32'(ok0[1]), 32'd1);
        check("t1_dout", dout0[63:32], 32'hDEADBEEF);
        slot_cs[1] = 1'b0;
        @(negedge clk);
        slot_cs[1] = 1'b1;
        #1;
        check("t1_rehit", 32'(ok0[1]), 32'd1);
        repeat (3) @(negedge clk);
        check("t1_no_req", 32'(req0), 32'd0);
        wait_done("t1");
        check("t1_fp_dout", dout1[63:32], 32'hDEADBEEF);
        slot_cs = '0;
        @(negedge clk);
        auto0 = 1'b1;

        // Vblank boost of slot3, then normal arbitration
        q0.push_back(22'h310); q0.push_back(22'h110);
        q1.push_back(22'h310); q1.push_back(22'h110);
        vblank = 1'b1;
        set_slot(0, 22'h110, 1'b1); set_slot(3, 22'h310, 1'b1);
        wait_done("t3a");
        vblank = 1'b0;
        q0.push_back(22'h320); q0.push_back(22'h120);
        q1.push_back(22'h120); q1.push_back(22'h320);
        set_slot(0, 22'h120, 1'b1); set_slot(3, 22'h320, 1'b1);
        wait_done("t3b");
        slot_cs = '0;
        @(negedge clk);
        auto0 = 1'b0;
        chk1  = 1'b0;

        // Address change while the fetch is in flight
        set_slot(2, 22'h20, 1'b1);
        wait_req0("t4a");
        check("t4_addr_a", 32'(saddr0), 32'h20);
        m_ack0 = 1'b1;
        @(negedge clk);
        m_ack0 = 1'b0;
        set_slot(2, 22'h21, 1'b1);
        m_rdy0 = 1'b1; m_rd0 = 32'h11112020;
        @(negedge clk);
        m_rdy0 = 1'b0;
        #1;
        check("t4_ok_stale", 32'(ok0[2]), 32'd0);
        check("t4_idle", 32'(req0), 32'd0);
        @(negedge clk);
        check("t4_req_b", 32'(req0), 32'd1);
        check("t4_addr_b", 32'(saddr0), 32'h21);
        set_slot(2, 22'h20, 1'b1);
        #1;
        check("t4_tag20_ok", 32'(ok0[2]), 32'd1);
        check("t4_tag20_dout", dout0[95:64], 32'h11112020);
        set_slot(2, 22'h21, 1'b1);
        m_ack0 = 1'b1;
        @(negedge clk);
        m_ack0 = 1'b0;

        // Loop reset during WAIT discards the late data and flushes every slot
        set_slot(2, 22'h21, 1'b0);
        loop_rst = 1'b1;
        @(negedge clk);
        loop_rst = 1'b0;
        check("t5_req", 32'(req0), 32'd0);
        check("t5_refresh", 32'(ref0), 32'd1);
        m_rdy0 = 1'b1; m_rd0 = 32'h22222121;
        @(negedge clk);
        m_rdy0 = 1'b0;
        set_slot(2, 22'h20, 1'b1);
        #1;
        check("t5_flushed", 32'(ok0[2]), 32'd0);
        set_slot(2, 22'h21, 1'b1);
        #1;
        check("t5_discard", 32'(ok0[2]), 32'd0);
        slot_cs[2] = 1'b0;
        #1;
        check("t5_refresh_idle", 32'(ref0), 32'd1);
        @(negedge clk);

        // Asynchronous reset mid-request, then download falling edge flush
        set_slot(0, 22'h40, 1'b1);
        wait_req0("t6a");
        check("t6_addr", 32'(saddr0), 32'h40);
        #2 rstn = 1'b0;
        #1;
        check("t6_rst_req", 32'(req0), 32'd0);
        check("t6_rst_addr", 32'(saddr0), 32'd0);
        check("t6_rst_ok", 32'(ok0), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        wait_req0("t6b");
        m_ack0 = 1'b1;
        @(negedge clk);
        m_ack0 = 1'b0;
        m_rdy0 = 1'b1; m_rd0 = 32'h33334040;
        @(negedge clk);
        m_rdy0 = 1'b0;
        check("t6_ok", 32'(ok0[0]), 32'd1);
        check("t6_dout", dout0[31:0], 32'h33334040);
        downloading = 1'b1;
        set_slot(3, 22'h50, 1'b1);
        repeat (4) @(negedge clk);
        check("t6_dl_hold", 32'(req0), 32'd0);
        check("t6_dl_keep", 32'(ok0[0]), 32'd1);
        downloading = 1'b0;
        @(negedge clk);
        #1;
        check("t6_dl_flush", 32'(ok0[0]), 32'd0);
        slot_cs = '0;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
